// File: rtl/hamming_pkg.sv
// Shared Hamming helpers for the SECDED encoder/decoder: code sizes, syndrome masks and
// packing/unpacking of data bits at the non-power-of-two codeword positions.
package hamming_pkg;

    localparam int unsigned CW_MAX = 64;
    localparam int unsigned IDX_W  = 6;

    function automatic int unsigned hamming_n(input int unsigned r);
        return (32'd1 << r) - 32'd1;
    endfunction

    function automatic int unsigned hamming_k(input int unsigned r);
        return hamming_n(r) - r;
    endfunction

    function automatic logic is_pow2(input int unsigned pos);
        return (pos != 32'd0) && ((pos & (pos - 32'd1)) == 32'd0);
    endfunction

    // Bit (pos-1) set for every position pos <= n whose index has bit j set.
    function automatic logic [CW_MAX-1:0] syndrome_mask(input int unsigned j, input int unsigned n);
        logic [CW_MAX-1:0] m;
        m = '0;
        for (int unsigned pos = 1; pos <= CW_MAX; pos++) begin
            if (pos <= n && ((pos >> j) & 32'd1) != 32'd0) begin
                m[IDX_W'(pos - 32'd1)] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [CW_MAX-1:0] extract_data(input logic [CW_MAX-1:0] cw,
                                                       input int unsigned n);
        logic [CW_MAX-1:0] d;
        int unsigned       k;
        d = '0;
        k = 0;
        for (int unsigned pos = 1; pos <= CW_MAX; pos++) begin
            if (pos <= n && !is_pow2(pos)) begin
                d[IDX_W'(k)] = cw[IDX_W'(pos - 32'd1)];
                k++;
            end
        end
        return d;
    endfunction

    function automatic logic [CW_MAX-1:0] insert_data(input logic [CW_MAX-1:0] d,
                                                      input int unsigned n);
        logic [CW_MAX-1:0] cw;
        int unsigned       k;
        cw = '0;
        k  = 0;
        for (int unsigned pos = 1; pos <= CW_MAX; pos++) begin
            if (pos <= n && !is_pow2(pos)) begin
                cw[IDX_W'(pos - 32'd1)] = d[IDX_W'(k)];
                k++;
            end
        end
        return cw;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome and overall-parity generator.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int unsigned R = 3
) (
    input  logic [hamming_n(R)-1:0] in,
    input  logic                    in_parity,
    output logic [R-1:0]            syndrome_c,
    output logic                    parity_c
);

    localparam int unsigned N = hamming_n(R);

    for (genvar j = 0; j < R; j++) begin : g_syn
        localparam logic [CW_MAX-1:0] MASK = syndrome_mask(j, N);
        assign syndrome_c[j] = ^(in & MASK[N-1:0]);
    end

    assign parity_c = ^{in, in_parity};

endmodule

// File: rtl/hamming_secded_pipe_decoder.sv
// Two-stage pipelined SECDED decoder with valid/ready handshake and saturating
// single/double error counters.
module hamming_secded_pipe_decoder
    import hamming_pkg::*;
#(
    parameter int unsigned R       = 3,
    parameter int unsigned COUNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [hamming_n(R)-1:0] in,
    input  logic                    in_parity,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    correct_en,
    output logic [hamming_k(R)-1:0] out,
    output logic                    error_1bit,
    output logic                    error_2bit,
    output logic [R-1:0]            syndrome,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    cnt_clear,
    output logic [COUNT_W-1:0]      cnt_1bit,
    output logic [COUNT_W-1:0]      cnt_2bit
);

    localparam int unsigned        N       = hamming_n(R);
    localparam int unsigned        K       = hamming_k(R);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic              en_c, hs_c;
    logic [R-1:0]      syn_c;
    logic              par_c;
    logic [N-1:0]      fixed_c;
    logic [CW_MAX-1:0] data_ext_c;

    logic               s1_valid_q, s1_valid_d;
    logic [N-1:0]       s1_cw_q, s1_cw_d;
    logic [R-1:0]       s1_syn_q, s1_syn_d;
    logic               s1_par_q, s1_par_d;
    logic               s1_cen_q, s1_cen_d;
    logic               out_valid_q, out_valid_d;
    logic [K-1:0]       out_q, out_d;
    logic               err1_q, err1_d;
    logic               err2_q, err2_d;
    logic [R-1:0]       syn_q, syn_d;
    logic [COUNT_W-1:0] cnt1_q, cnt1_d;
    logic [COUNT_W-1:0] cnt2_q, cnt2_d;

    hamming_syndrome #(.R(R)) u_syn (
        .in         (in),
        .in_parity  (in_parity),
        .syndrome_c (syn_c),
        .parity_c   (par_c)
    );

    assign en_c     = ~out_valid_q | out_ready;
    assign hs_c     = out_valid_q & out_ready;
    assign in_ready = en_c;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_cw_d     = s1_cw_q;
        s1_syn_d    = s1_syn_q;
        s1_par_d    = s1_par_q;
        s1_cen_d    = s1_cen_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        err1_d      = err1_q;
        err2_d      = err2_q;
        syn_d       = syn_q;
        cnt1_d      = cnt1_q;
        cnt2_d      = cnt2_q;

        // Flip the addressed position only for a correctable error with correction enabled.
        fixed_c = s1_cw_q;
        if (s1_syn_q != '0 && s1_par_q && s1_cen_q) begin
            fixed_c = s1_cw_q ^ (N'(1) << (s1_syn_q - R'(1)));
        end
        data_ext_c = extract_data(CW_MAX'(fixed_c), N);

        if (en_c) begin
            s1_valid_d  = in_valid;
            s1_cw_d     = in;
            s1_syn_d    = syn_c;
            s1_par_d    = par_c;
            s1_cen_d    = correct_en;
            out_valid_d = s1_valid_q;
            out_d       = data_ext_c[K-1:0];
            err1_d      = s1_par_q;
            err2_d      = (s1_syn_q != '0) && !s1_par_q;
            syn_d       = s1_syn_q;
        end

        // Clear takes priority over a same-cycle increment.
        if (cnt_clear) begin
            cnt1_d = '0;
            cnt2_d = '0;
        end else begin
            if (hs_c && err1_q && cnt1_q != CNT_MAX) cnt1_d = cnt1_q + COUNT_W'(1);
            if (hs_c && err2_q && cnt2_q != CNT_MAX) cnt2_d = cnt2_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_cw_q     <= '0;
            s1_syn_q    <= '0;
            s1_par_q    <= 1'b0;
            s1_cen_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            err1_q      <= 1'b0;
            err2_q      <= 1'b0;
            syn_q       <= '0;
            cnt1_q      <= '0;
            cnt2_q      <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_cw_q     <= s1_cw_d;
            s1_syn_q    <= s1_syn_d;
            s1_par_q    <= s1_par_d;
            s1_cen_q    <= s1_cen_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            err1_q      <= err1_d;
            err2_q      <= err2_d;
            syn_q       <= syn_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
        end
    end

    assign out        = out_q;
    assign error_1bit = err1_q;
    assign error_2bit = err2_q;
    assign syndrome   = syn_q;
    assign out_valid  = out_valid_q;
    assign cnt_1bit   = cnt1_q;
    assign cnt_2bit   = cnt2_q;

endmodule
